pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/global_pkg.sv | 19 +
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/digit_adder.sv | 25 ++
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/global_pkg.sv
`default_nettype none
// ============================================================================
// Module      : global_pkg
// Description : Shared types and constants for the PC sequencer slice.
// Revision    : 1.0  initial release
// ============================================================================
package global_pkg;

   // Sequencer states: IDLE samples requests, SHIFT runs the serial increment
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } pcs_state_t;

   // Increment step applied by inc_req (must be a power of two)
   localparam int PC_STEP = 4;

endpackage : global_pkg
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Request / status bundle between a requester and pc_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if
   import global_pkg::*;
#(
   parameter int XLEN = 32
);
   logic              inc_req;
   logic              load_req;
   logic              trap_req;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   epc;
   logic              busy;
   logic              done;
   logic              misaligned;

   modport master (
      output inc_req, load_req, trap_req, target,
      input  pc, epc, busy, done, misaligned
   );

   modport slave (
      input  inc_req, load_req, trap_req, target,
      output pc, epc, busy, done, misaligned
   );
endinterface : pc_sequencer_if
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_adder
// Description : DIGIT_W-bit combinational adder with carry-in and carry-out,
//               the only arithmetic used by the serial PC increment.
// Revision    : 1.0  initial release
// ============================================================================
module digit_adder
   import global_pkg::*;
#(
   parameter int DIGIT_W = 1
) (
   input  wire logic [DIGIT_W-1:0] i_a,
   input  wire logic [DIGIT_W-1:0] i_b,
   input  wire logic               i_cin,
   output logic      [DIGIT_W-1:0] o_sum,
   output logic                    o_cout
);
   logic [DIGIT_W:0] w_total;

   assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_cin};
   assign o_sum   = w_total[DIGIT_W-1:0];
   assign o_cout  = w_total[DIGIT_W];
endmodule : digit_adder
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter with trap/load/increment requests. The +4
//               increment is done digit-serially: each SHIFT cycle adds one
//               DIGIT_W-bit digit at the bottom of pc and rotates the result
//               in at the top, so after XLEN/DIGIT_W cycles pc is back in
//               order holding old_pc + 4.
// Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
   import global_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              DIGIT_W      = 1,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h00000010)
) (
   input wire logic      clk,
   input wire logic      rst,
   pc_sequencer_if.slave bus
);
   localparam int                c_NUM_DIGITS = XLEN / DIGIT_W;
   localparam int                CNT_W        = $clog2(c_NUM_DIGITS) + 1;
   localparam logic [CNT_W-1:0]  c_LAST_DIGIT = CNT_W'(c_NUM_DIGITS - 1);
   // PC_STEP is a power of two, so exactly one digit of it is non-zero
   localparam int                c_STEP_IDX_I = $clog2(PC_STEP) / DIGIT_W;
   localparam logic [CNT_W-1:0]  c_STEP_IDX   = CNT_W'(c_STEP_IDX_I);
   localparam logic [DIGIT_W-1:0] c_STEP_DIGIT =
      DIGIT_W'(PC_STEP >> (c_STEP_IDX_I * DIGIT_W));

   pcs_state_t         r_state;
   pcs_state_t         w_next_state;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_epc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_done;
   logic               r_mis;

   logic               w_do_trap;
   logic               w_do_load;
   logic               w_do_inc;
   logic               w_do_shift;
   logic               w_finish;
   logic               w_mis;
   logic [DIGIT_W-1:0] w_step_digit;
   logic [DIGIT_W-1:0] w_sum;
   logic               w_cout;
   logic [XLEN-1:0]    w_pc_shifted;

   assign w_step_digit = (r_cnt == c_STEP_IDX) ? c_STEP_DIGIT : '0;

   digit_adder #(
      .DIGIT_W (DIGIT_W)
   ) u_digit_adder (
      .i_a    (r_pc[DIGIT_W-1:0]),
      .i_b    (w_step_digit),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // New digit enters at the top; with a single digit the sum is the whole pc
   generate
      if (DIGIT_W == XLEN) begin : g_single_digit
         assign w_pc_shifted = w_sum;
      end else begin : g_multi_digit
         assign w_pc_shifted = {w_sum, r_pc[XLEN-1:DIGIT_W]};
      end
   endgenerate

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state and request decode; trap beats load beats increment
   always_comb begin
      w_next_state = r_state;
      w_do_trap    = 1'b0;
      w_do_load    = 1'b0;
      w_do_inc     = 1'b0;
      w_do_shift   = 1'b0;
      w_finish     = 1'b0;
      w_mis        = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.trap_req) begin
               w_do_trap = 1'b1;
            end else if (bus.load_req) begin
               if (bus.target[1:0] != 2'b00) begin
                  w_do_trap = 1'b1;
                  w_mis     = 1'b1;
               end else begin
                  w_do_load = 1'b1;
               end
            end else if (bus.inc_req) begin
               w_do_inc     = 1'b1;
               w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            w_do_shift = 1'b1;
            if (r_cnt == c_LAST_DIGIT) begin
               w_finish     = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // PC / EPC datapath, digit counter, carry and registered status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_VECTOR;
         r_epc   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_done  <= 1'b0;
         r_mis   <= 1'b0;
      end else begin
         r_done <= w_do_trap | w_do_load | w_finish;
         r_mis  <= w_mis;
         if (w_do_trap) begin
            r_epc <= r_pc;
            r_pc  <= TRAP_VECTOR;
         end else if (w_do_load) begin
            r_pc  <= bus.target;
         end else if (w_do_inc) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
         end else if (w_do_shift) begin
            r_pc    <= w_pc_shifted;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.pc         = r_pc;
   assign bus.epc        = r_epc;
   assign bus.busy       = (r_state == SHIFT);
   assign bus.done       = r_done;
   assign bus.misaligned = r_mis;

endmodule : pc_sequencer
`default_nettype wire
